pwm_bank: RTL and testbench

Parametrised multi-channel PWM generator that replaces the per-output motor, servo and PWM1 generators in the `gc` fabric with one shared block. It provides NCH independent channels, each with its own period, duty, prescaler, enable and polarity. Writes go to shadow registers and are applied glitch-free at each channel's period boundary. The block sits behind the MSS register bridge and drives the motor, servo and auxiliary PWM pins.

---
 rtl/pwm_bank.sv | 91 +++++++++
 tb/tb_pwm_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// pwm_bank - NCH-channel PWM generator with shadowed period/duty applied at each period wrap.
// Optional PWM_BANK_DUTY_CLAMP_EN: duty writes above the current shadow period are stored as that period.
module pwm_bank #(
  parameter int NCH = 5,
  parameter int CW  = 16
) (
  input  logic           SYSCLK,
  input  logic           NSYSRESET,
  input  logic           wr_en,
  input  logic [3:0]     wr_ch,
  input  logic [1:0]     wr_sel,
  input  logic [CW-1:0]  wr_data,
  output logic [NCH-1:0] pwm_out,
  output logic [NCH-1:0] period_tick
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] r_period_s, r_duty_s, r_period_a, r_duty_a, r_cnt;
    logic [7:0]    r_pre, r_prescale;
    logic          r_en, r_inv, r_wrap, r_pwm, r_tick;
    logic          w_sel_ch, w_tick, w_wrap;
    logic [CW-1:0] w_duty_wr;

    assign w_sel_ch = wr_en && (wr_ch == 4'(g));
    assign w_tick   = (r_pre == r_prescale);
    assign w_wrap   = r_en && w_tick && (r_cnt == r_period_a);

`ifdef PWM_BANK_DUTY_CLAMP_EN
    assign w_duty_wr = (wr_data > r_period_s) ? r_period_s : wr_data;
`else
    assign w_duty_wr = wr_data;
`endif

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
      if (!NSYSRESET) begin
        r_period_s <= '0;
        r_duty_s   <= '0;
        r_period_a <= '0;
        r_duty_a   <= '0;
        r_cnt      <= '0;
        r_pre      <= '0;
        r_prescale <= '0;
        r_en       <= 1'b0;
        r_inv      <= 1'b0;
        r_wrap     <= 1'b0;
        r_pwm      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        if (w_sel_ch) begin
          case (wr_sel)
            2'd0: r_period_s <= wr_data;
            2'd1: r_duty_s   <= w_duty_wr;
            2'd2: begin
              r_prescale <= wr_data[7:0];
              r_en       <= wr_data[8];
              r_inv      <= wr_data[9];
            end
            default: ;
          endcase
        end

        // Output and tick are delayed one stage so period_tick lines up with the pwm sample of cnt = 0.
        r_pwm  <= r_en ? ((r_cnt < r_duty_a) ^ r_inv) : r_inv;
        r_wrap <= w_wrap;
        r_tick <= r_wrap;

        if (!r_en) begin
          r_pre      <= '0;
          r_cnt      <= '0;
          r_period_a <= r_period_s;
          r_duty_a   <= r_duty_s;
        end else if (w_tick) begin
          r_pre <= '0;
          if (r_cnt == r_period_a) begin
            r_cnt      <= '0;
            r_period_a <= r_period_s;
            r_duty_a   <= r_duty_s;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          r_pre <= r_pre + 8'd1;
        end
      end
    end

    assign pwm_out[g]     = r_pwm;
    assign period_tick[g] = r_tick;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed and randomized checks of pwm_bank against a period-position reference model.
module tb_pwm_bank;
  localparam int NCH = 5;
  localparam int CW  = 16;

  logic           SYSCLK = 1'b0;
  logic           NSYSRESET;
  logic           wr_en;
  logic [3:0]     wr_ch;
  logic [1:0]     wr_sel;
  logic [CW-1:0]  wr_data;
  logic [NCH-1:0] pwm_out;
  logic [NCH-1:0] period_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: k = cycles elapsed in the current period; cnt = k / (prescale+1).
  int m_en[NCH], m_inv[NCH], m_ps[NCH], m_pers[NCH], m_dutys[NCH];
  int m_pera[NCH], m_dutya[NCH], m_k[NCH], m_wrap[NCH];
  logic [NCH-1:0] m_pwm, m_tick;

  pwm_bank #(.NCH(NCH), .CW(CW)) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_sel(wr_sel), .wr_data(wr_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 SYSCLK = ~SYSCLK;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_inv[c] = 0; m_ps[c] = 0; m_pers[c] = 0; m_dutys[c] = 0;
      m_pera[c] = 0; m_dutya[c] = 0; m_k[c] = 0; m_wrap[c] = 0;
    end
    m_pwm  = '0;
    m_tick = '0;
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (m_en[c] != 0)
        m_pwm[c] = ((m_k[c] / (m_ps[c] + 1)) < m_dutya[c]) ^ (m_inv[c] != 0);
      else
        m_pwm[c] = (m_inv[c] != 0);
      m_tick[c] = (m_wrap[c] != 0);
      if (m_en[c] != 0 && m_k[c] + 1 == (m_pera[c] + 1) * (m_ps[c] + 1)) begin
        m_k[c] = 0; m_pera[c] = m_pers[c]; m_dutya[c] = m_dutys[c]; m_wrap[c] = 1;
      end else if (m_en[c] != 0) begin
        m_k[c] = m_k[c] + 1; m_wrap[c] = 0;
      end else begin
        m_k[c] = 0; m_pera[c] = m_pers[c]; m_dutya[c] = m_dutys[c]; m_wrap[c] = 0;
      end
    end
    if (wr_en && int'(wr_ch) < NCH) begin
      case (wr_sel)
        2'd0: m_pers[wr_ch] = int'(wr_data);
`ifdef PWM_BANK_DUTY_CLAMP_EN
        2'd1: m_dutys[wr_ch] = (int'(wr_data) > m_pers[wr_ch]) ? m_pers[wr_ch] : int'(wr_data);
`else
        2'd1: m_dutys[wr_ch] = int'(wr_data);
`endif
        2'd2: begin
          m_ps[wr_ch]  = int'(wr_data[7:0]);
          m_en[wr_ch]  = int'(wr_data[8]);
          m_inv[wr_ch] = int'(wr_data[9]);
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    n_cmp++;
    assert (pwm_out === m_pwm) else begin
      n_bad++;
      $error("FAIL %s pwm_out observed=%b expected=%b", tag, pwm_out, m_pwm);
    end
    n_cmp++;
    assert (period_tick === m_tick) else begin
      n_bad++;
      $error("FAIL %s period_tick observed=%b expected=%b", tag, period_tick, m_tick);
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input int ch, input int sel, input int data);
    wr_en   = en;
    wr_ch   = ch[3:0];
    wr_sel  = sel[1:0];
    wr_data = data[CW-1:0];
    @(posedge SYSCLK);
    model_edge();
    #1;
    wr_en = 1'b0;
    check_all("step");
  endtask

  task automatic window(input int ch, input int n, output int highs, output int ticks);
    highs = 0;
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 0, 0, 0);
      highs += int'(pwm_out[ch]);
      ticks += int'(period_tick[ch]);
    end
  endtask

  task automatic wait_tick(input int ch);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 0, 0, 0);
      found = period_tick[ch];
    end
    n_cmp++;
    assert (found) else begin
      n_bad++;
      $error("FAIL wait_tick ch%0d observed=timeout expected=tick", ch);
    end
  endtask

  initial begin
    int hi, tk, ch, sel, data;
    NSYSRESET = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      @(posedge SYSCLK);
      #1;
      check_all("reset_hold");
    end
    NSYSRESET = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 0);

    // Basic waveform on ch0: 3 high / 7 low, one tick per 10 cycles.
    step(1'b1, 0, 0, 9);
    step(1'b1, 0, 1, 3);
    step(1'b1, 0, 2, 'h100);
    wait_tick(0);
    window(0, 10, hi, tk);
    expect_int("basic_high", hi, 3);
    expect_int("basic_tick", tk, 1);

    // Shadow update: duty 7 written at cnt = 5.
    wait_tick(0);
    hi = 1;
    for (int i = 1; i < 10; i++) begin
      if (i == 5) step(1'b1, 0, 1, 7);
      else step(1'b0, 0, 0, 0);
      hi += int'(pwm_out[0]);
    end
    expect_int("shadow_cur_high", hi, 3);
    window(0, 10, hi, tk);
    expect_int("shadow_next_high", hi, 7);
    expect_int("shadow_next_tick", tk, 1);

    // Prescale 1 with invert on ch2: 4 low / 6 high over 10 cycles.
    step(1'b1, 2, 0, 4);
    step(1'b1, 2, 1, 2);
    step(1'b1, 2, 2, 'h301);
    wait_tick(2);
    window(2, 10, hi, tk);
    expect_int("prescale_high", hi, 6);
    expect_int("prescale_tick", tk, 1);
    window(2, 20, hi, tk);
    expect_int("prescale_tick20", tk, 2);

    // Boundary duty on ch1.
    step(1'b1, 1, 0, 9);
    step(1'b1, 1, 1, 0);
    step(1'b1, 1, 2, 'h100);
    window(1, 12, hi, tk);
    expect_int("duty0_high", hi, 0);
    wait_tick(1);
    step(1'b1, 1, 1, 20);
    wait_tick(1);
    window(1, 10, hi, tk);
`ifdef PWM_BANK_DUTY_CLAMP_EN
    expect_int("duty_over_high", hi, 9);
`else
    expect_int("duty_over_high", hi, 10);
`endif

    // Invalid channel and register select.
    step(1'b1, 7, 0, 3);
    step(1'b1, 7, 2, 'h100);
    step(1'b1, 0, 3, 'h3ff);
    step(1'b1, 15, 1, 1);
    window(0, 10, hi, tk);
    expect_int("invalid_ch0_high", hi, 7);

    // Randomized writes; prescale changes only land on disabled channels.
    for (int i = 0; i < 600; i++) begin
      ch  = int'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: data = int'($urandom_range(0, 12));
        1: data = int'($urandom_range(0, 15));
        2: begin
          data = int'($urandom_range(0, 1)) << 9;
          if (ch < NCH && m_en[ch] != 0)
            data = data | int'($urandom_range(0, 3));
          else
            data = data | ((($urandom_range(0, 3) != 0) ? 1 : 0) << 8) | int'($urandom_range(0, 3));
        end
        default: data = int'($urandom);
      endcase
      step($urandom_range(0, 1) == 1, ch, sel, data);
    end

    // Asynchronous reset mid-period.
    #3;
    NSYSRESET = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge SYSCLK);
      #1;
      check_all("reset_mid_hold");
    end
    NSYSRESET = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 0);
    expect_int("idle_after_reset", int'(pwm_out) + int'(period_tick), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
